// File: rtl/pm_seq_pkg.sv
// pm_seq_pkg -- shared types and widths for the path-metric sequencer.
//   pm_state_e : sequencer FSM states
//   ADDR_W     : path-metric address width
//   ID_W       : frame tag width
//   PM_W       : path-metric word width (downstream datapath)
//   STEP_W     : trellis step index width
package pm_seq_pkg;

    localparam int ADDR_W = 2;
    localparam int ID_W   = 3;
    localparam int PM_W   = 7;
    localparam int STEP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        TAIL,
        FLUSH,
        DONE
    } pm_state_e;

endpackage

// File: rtl/pm_slot_cnt.sv
// pm_slot_cnt -- address/step counter for the path-metric sequencer.
//   PM_clk : clock
//   PM_rst : asynchronous active-low reset
//   clr    : synchronous clear of address and step
//   adv    : advance to the next slot
//   addr   : current path-metric address (0..NUM_STATES-1)
//   step   : current trellis step, saturating at all-ones
//   wrap   : address is at its last value (next advance ends the step)
module pm_slot_cnt
    import pm_seq_pkg::*;
#(
    parameter int NUM_STATES = 4
) (
    input  logic              PM_clk,
    input  logic              PM_rst,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [STEP_W-1:0] step,
    output logic              wrap
);

    assign wrap = (addr == ADDR_W'(NUM_STATES - 1));

    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            addr <= '0;
            step <= '0;
        end else if (clr) begin
            addr <= '0;
            step <= '0;
        end else if (adv) begin
            if (wrap) begin
                addr <= '0;
                // A 255-step frame plus tail runs past 255; hold at the top.
                if (step != '1) begin
                    step <= step + 1'b1;
                end
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pm_seq_ctrl.sv
// pm_seq_ctrl -- path-metric address sequencer for a trellis decoder.
// Walks every path-metric address for each data step of a frame, then the
// termination steps, then idles for a pipeline flush and pulses done.
// Optional build macro: PM_SEQ_ABORT_EN adds the abort input.
//   PM_clk      : clock
//   PM_rst      : asynchronous active-low reset
//   start       : frame request, taken only when idle
//   frame_len   : data steps in the frame, latched with start
//   stall       : hold the sequencer for this cycle (RUN/TAIL only)
//   abort       : (PM_SEQ_ABORT_EN) drop the current frame, no done
//   valid_out   : an address slot is issued
//   addr_out    : path-metric address of the slot
//   dec_out     : store the survivor decision for the slot
//   term_out    : trellis terminating, or sequencer not in RUN
//   data_id_out : frame tag, bumped on each accepted start
//   step_out    : trellis step of the slot
//   busy        : frame in progress
//   done        : one-cycle frame completion pulse
// Outputs are registered: each reflects the decision taken at the
// previous clock edge.
module pm_seq_ctrl
    import pm_seq_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int TAIL_LEN   = 2,
    parameter int FLUSH_LEN  = 2
) (
    input  logic              PM_clk,
    input  logic              PM_rst,
    input  logic              start,
    input  logic [7:0]        frame_len,
    input  logic              stall,
`ifdef PM_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              valid_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              dec_out,
    output logic              term_out,
    output logic [ID_W-1:0]   data_id_out,
    output logic [STEP_W-1:0] step_out,
    output logic              busy,
    output logic              done
);

    pm_state_e         state;
    logic [STEP_W-1:0] len_q;
    logic [STEP_W-1:0] tail_cnt;
    logic [STEP_W-1:0] flush_cnt;

    logic              abort_i;
    logic              cnt_clr;
    logic              cnt_adv;
    logic [ADDR_W-1:0] cnt_addr;
    logic [STEP_W-1:0] cnt_step;
    logic              cnt_wrap;

`ifdef PM_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Counters are parked at zero while idle so a new frame starts at slot 0.
    assign cnt_clr = (state == IDLE);
    assign cnt_adv = ((state == RUN) || (state == TAIL)) && !stall && !abort_i;

    pm_slot_cnt #(
        .NUM_STATES (NUM_STATES)
    ) u_slot_cnt (
        .PM_clk (PM_clk),
        .PM_rst (PM_rst),
        .clr    (cnt_clr),
        .adv    (cnt_adv),
        .addr   (cnt_addr),
        .step   (cnt_step),
        .wrap   (cnt_wrap)
    );

    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            state       <= IDLE;
            len_q       <= '0;
            tail_cnt    <= '0;
            flush_cnt   <= '0;
            valid_out   <= 1'b0;
            addr_out    <= '0;
            dec_out     <= 1'b0;
            term_out    <= 1'b1;
            data_id_out <= '0;
            step_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_i && ((state == RUN) || (state == TAIL) || (state == FLUSH))) begin
                // Abandon the frame: reset-state outputs, tag kept.
                state     <= IDLE;
                valid_out <= 1'b0;
                addr_out  <= '0;
                dec_out   <= 1'b0;
                term_out  <= 1'b1;
                step_out  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        valid_out <= 1'b0;
                        dec_out   <= 1'b0;
                        term_out  <= 1'b1;
                        busy      <= 1'b0;
                        if (start) begin
                            len_q       <= frame_len;
                            tail_cnt    <= '0;
                            flush_cnt   <= '0;
                            addr_out    <= '0;
                            step_out    <= '0;
                            busy        <= 1'b1;
                            data_id_out <= data_id_out + 1'b1;
                            if (frame_len == '0) begin
                                state <= TAIL;
                            end else begin
                                state    <= RUN;
                                term_out <= 1'b0;
                            end
                        end
                    end
                    RUN, TAIL: begin
                        // While stalled the pending slot is shown with valid low.
                        addr_out  <= cnt_addr;
                        step_out  <= cnt_step;
                        valid_out <= !stall;
                        dec_out   <= !stall;
                        term_out  <= (state != RUN);
                        if (!stall && cnt_wrap) begin
                            if (state == RUN) begin
                                if (cnt_step == len_q - 8'd1) begin
                                    state <= TAIL;
                                end
                            end else if (tail_cnt == STEP_W'(TAIL_LEN - 1)) begin
                                state <= FLUSH;
                            end else begin
                                tail_cnt <= tail_cnt + 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        valid_out <= 1'b0;
                        dec_out   <= 1'b0;
                        term_out  <= 1'b1;
                        if (flush_cnt == STEP_W'(FLUSH_LEN - 1)) begin
                            state <= DONE;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        valid_out <= 1'b0;
                        dec_out   <= 1'b0;
                        term_out  <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pm_seq_ctrl.sv
module tb_pm_seq_ctrl;

    localparam int N      = 4;
    localparam int TAIL   = 2;
    localparam int FLUSHN = 2;

    logic       PM_clk;
    logic       PM_rst;
    logic       start;
    logic [7:0] frame_len;
    logic       stall;
    logic       abort_s;
    logic       valid_out;
    logic [1:0] addr_out;
    logic       dec_out;
    logic       term_out;
    logic [2:0] data_id_out;
    logic [7:0] step_out;
    logic       busy;
    logic       done;

    pm_seq_ctrl #(
        .NUM_STATES (N),
        .TAIL_LEN   (TAIL),
        .FLUSH_LEN  (FLUSHN)
    ) dut (
        .PM_clk      (PM_clk),
        .PM_rst      (PM_rst),
        .start       (start),
        .frame_len   (frame_len),
        .stall       (stall),
`ifdef PM_SEQ_ABORT_EN
        .abort       (abort_s),
`endif
        .valid_out   (valid_out),
        .addr_out    (addr_out),
        .dec_out     (dec_out),
        .term_out    (term_out),
        .data_id_out (data_id_out),
        .step_out    (step_out),
        .busy        (busy),
        .done        (done)
    );

    initial PM_clk = 1'b0;
    always #5 PM_clk = ~PM_clk;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level reference: a frame is a list of slots numbered k;
    // slot k has address k%N and step k/N, and is a tail slot once k
    // passes frame_len*N.
    int         m_phase;   // 0 idle, 1 slots, 2 flush, 3 done
    int         m_k;
    int         m_run_slots;
    int         m_total;
    int         m_f;
    logic [2:0] m_id;

    logic       e_valid, e_dec, e_term, e_busy, e_done;
    logic [1:0] e_addr;
    logic [7:0] e_step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
        chk("addr_out", {30'd0, addr_out}, {30'd0, e_addr});
        chk("dec_out", {31'd0, dec_out}, {31'd0, e_dec});
        chk("term_out", {31'd0, term_out}, {31'd0, e_term});
        chk("data_id_out", {29'd0, data_id_out}, {29'd0, m_id});
        chk("step_out", {24'd0, step_out}, {24'd0, e_step});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("done", {31'd0, done}, {31'd0, done ? e_done : e_done});
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_k     = 0;
        m_id    = '0;
        e_valid = 1'b0;
        e_dec   = 1'b0;
        e_term  = 1'b1;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_addr  = '0;
        e_step  = '0;
    endtask

    task automatic model_step(input logic st, input logic [7:0] fl, input logic sl, input logic ab);
        int s;
        e_done = 1'b0;
        if (ab && (m_phase == 1 || m_phase == 2)) begin
            m_phase = 0;
            e_valid = 1'b0;
            e_dec   = 1'b0;
            e_term  = 1'b1;
            e_busy  = 1'b0;
            e_addr  = '0;
            e_step  = '0;
        end else begin
            case (m_phase)
                0: begin
                    e_valid = 1'b0;
                    e_dec   = 1'b0;
                    e_term  = 1'b1;
                    e_busy  = 1'b0;
                    if (st) begin
                        m_id        = m_id + 3'd1;
                        m_run_slots = int'(fl) * N;
                        m_total     = (int'(fl) + TAIL) * N;
                        m_k         = 0;
                        m_phase     = 1;
                        e_busy      = 1'b1;
                        e_addr      = '0;
                        e_step      = '0;
                        e_term      = (fl == 8'd0);
                    end
                end
                1: begin
                    s       = m_k / N;
                    e_addr  = 2'(m_k % N);
                    e_step  = (s > 255) ? 8'd255 : 8'(s);
                    e_term  = (m_k >= m_run_slots);
                    e_valid = !sl;
                    e_dec   = !sl;
                    if (!sl) begin
                        m_k++;
                        if (m_k == m_total) begin
                            m_phase = 2;
                            m_f     = 0;
                        end
                    end
                end
                2: begin
                    e_valid = 1'b0;
                    e_dec   = 1'b0;
                    e_term  = 1'b1;
                    m_f++;
                    if (m_f == FLUSHN) m_phase = 3;
                end
                default: begin
                    e_valid = 1'b0;
                    e_dec   = 1'b0;
                    e_term  = 1'b1;
                    e_busy  = 1'b0;
                    e_done  = 1'b1;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic cycle(input logic st, input logic [7:0] fl, input logic sl, input logic ab);
        logic ab_eff;
`ifdef PM_SEQ_ABORT_EN
        ab_eff = ab;
`else
        ab_eff = 1'b0;
`endif
        start     = st;
        frame_len = fl;
        stall     = sl;
        abort_s   = ab_eff;
        model_step(st, fl, sl, ab_eff);
        @(posedge PM_clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        start   = 1'b0;
        stall   = 1'b0;
        abort_s = 1'b0;
        PM_rst  = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(posedge PM_clk);
        #1;
        compare_all();
        PM_rst = 1'b1;
    endtask

    // smode: 0 no stall, 1 three stalls at step 1 addr 2, 2 random stalls
    task automatic run_frame(input logic [7:0] fl, input int smode,
                             output int cyc, output int nvalid, output int nterm0,
                             output int ndone, output int maxstep);
        int   stalls;
        bit   seen;
        logic sl;
        cyc = 0; nvalid = 0; nterm0 = 0; ndone = 0; maxstep = 0;
        stalls = 0; seen = 0;
        cycle(1'b1, fl, 1'b0, 1'b0);
        cyc = 1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            sl = 1'b0;
            if (smode == 1 && m_phase == 1 && m_k == N + 2 && stalls < 3) begin
                sl = 1'b1;
                stalls++;
            end else if (smode == 2) begin
                sl = ($urandom_range(0, 3) == 0);
            end
            cycle(1'b0, fl, sl, 1'b0);
            cyc++;
            if (valid_out) nvalid++;
            if (valid_out && !term_out) nterm0++;
            if (valid_out && int'(step_out) > maxstep) maxstep = int'(step_out);
            if (done) begin
                ndone++;
                seen = 1;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        for (int j = 0; j < 2; j++) begin
            cycle(1'b0, 8'd0, 1'b0, 1'b0);
            if (done) ndone++;
        end
    endtask

    int cyc, nv, nt0, nd, mx, base_cyc;

    initial begin
        PM_rst    = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        stall     = 1'b0;
        abort_s   = 1'b0;
        model_reset();
        @(posedge PM_clk);
        #1;
        do_reset();

        // Frame of 3 data steps.
        run_frame(8'd3, 0, cyc, nv, nt0, nd, mx);
        chk("f3_slots", 32'(nv), 32'd20);
        chk("f3_term0_slots", 32'(nt0), 32'd12);
        chk("f3_done_pulses", 32'(nd), 32'd1);
        chk("f3_cycles", 32'(cyc), 32'd24);
        chk("f3_id", {29'd0, data_id_out}, 32'd1);
        base_cyc = cyc;

        // Empty frame: tail only.
        run_frame(8'd0, 0, cyc, nv, nt0, nd, mx);
        chk("f0_slots", 32'(nv), 32'd8);
        chk("f0_term0_slots", 32'(nt0), 32'd0);
        chk("f0_max_step", 32'(mx), 32'd1);
        chk("f0_done_pulses", 32'(nd), 32'd1);

        // Three stall cycles at step 1 addr 2.
        run_frame(8'd3, 1, cyc, nv, nt0, nd, mx);
        chk("stall_cycles", 32'(cyc), 32'(base_cyc + 3));
        chk("stall_slots", 32'(nv), 32'd20);

        // Start while busy is dropped; then back-to-back frames.
        do_reset();
        cycle(1'b1, 8'd2, 1'b0, 1'b0);
        chk("busy_frame_id", {29'd0, data_id_out}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'd2, 1'b0, 1'b0);
        cycle(1'b1, 8'd5, 1'b0, 1'b0);
        chk("busy_start_id", {29'd0, data_id_out}, 32'd1);
        for (int i = 0; i < 40 && m_phase != 0; i++) cycle(1'b0, 8'd2, 1'b0, 1'b0);
        for (int f = 0; f < 8; f++) begin
            run_frame(8'($urandom_range(0, 3)), 2, cyc, nv, nt0, nd, mx);
            chk("b2b_id", {29'd0, data_id_out}, 32'((f + 2) % 8));
            chk("b2b_done_pulses", 32'(nd), 32'd1);
        end

        // Reset in the middle of the tail.
        cycle(1'b1, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(m_phase == 1 && m_k >= N + 1); i++)
            cycle(1'b0, 8'd1, 1'b0, 1'b0);
        chk("pre_rst_term", {31'd0, term_out}, 32'd1);
        do_reset();
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'd1, 1'b0, 1'b0);
            if (done) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'd0);
        run_frame(8'd2, 0, cyc, nv, nt0, nd, mx);
        chk("rst_first_id", {29'd0, data_id_out}, 32'd1);

        // Longest frame: step index saturates in the tail.
        run_frame(8'd255, 0, cyc, nv, nt0, nd, mx);
        chk("f255_slots", 32'(nv), 32'd1028);
        chk("f255_max_step", 32'(mx), 32'd255);

`ifdef PM_SEQ_ABORT_EN
        // Abort during data step 2, with stall asserted to show priority.
        cycle(1'b1, 8'd4, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(m_phase == 1 && m_k == 2 * N); i++)
            cycle(1'b0, 8'd4, 1'b0, 1'b0);
        begin
            logic [2:0] id_before;
            id_before = m_id;
            cycle(1'b0, 8'd4, 1'b1, 1'b1);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_valid", {31'd0, valid_out}, 32'd0);
            chk("abort_id", {29'd0, data_id_out}, {29'd0, id_before});
        end
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'd4, 1'b0, 1'b0);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
`endif

        // Random frames with random stalls and idle gaps.
        for (int f = 0; f < 20; f++) begin
            run_frame(8'($urandom_range(0, 6)), 2, cyc, nv, nt0, nd, mx);
            chk("rnd_done_pulses", 32'(nd), 32'd1);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++)
                cycle(1'b0, 8'($urandom), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
